// File: rtl/pe_lsc_pkg.sv
// Shared definitions for the PE local store sequencer: op encodings, FSM states, default widths.
package pe_lsc_pkg;
    localparam int unsigned LSC_A   = 7;
    localparam int unsigned LSC_L   = 8;
    localparam int unsigned LSC_OPW = 2;

    localparam logic [1:0] OP_LOAD_K = 2'd0;
    localparam logic [1:0] OP_LOAD_N = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_K,
        ST_LOAD_N,
        ST_RUN,
        ST_FIN
    } state_e;
endpackage

// File: rtl/lsc_addr_counter.sv
// Wrapping store address pointer: loads a base address, advances by a step, wraps modulo 2^A.
module lsc_addr_counter
    import pe_lsc_pkg::*;
#(
    parameter int unsigned A = LSC_A
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [A-1:0] base_i,
    input  logic [A-1:0] step_i,
    output logic [A-1:0] ptr_o
);
    logic [A-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = base_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + step_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/pe_local_store_sequencer.sv
// Per-PE kernel/neuron store sequencer: loads and dot-product sweeps with MAC handshaking.
// Build option: define LSC_STRIDE_EN to step the neuron pointer by cmd_stride during RUN.
module pe_local_store_sequencer
    import pe_lsc_pkg::*;
#(
    parameter int unsigned A   = LSC_A,
    parameter int unsigned L   = LSC_L,
    parameter int unsigned OPW = LSC_OPW
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [A-1:0]   cmd_kbase,
    input  logic [A-1:0]   cmd_nbase,
    input  logic [L-1:0]   cmd_len,
    input  logic [A-1:0]   cmd_stride,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mac_ready,
    output logic [A-1:0]   kernelAddress,
    output logic [A-1:0]   neuronAddress,
    output logic           kernelWrite,
    output logic           neuronWrite,
    output logic           mac_valid,
    output logic           mac_first,
    output logic           mac_last,
    output logic           busy,
    output logic           done
);
    state_e       state_q, state_d;
    logic [L-1:0] cnt_q, cnt_d, cnt_dec;
    logic         first_q, first_d;
    logic         accept, cnt_last;
    logic         k_inc, n_inc;
    logic [A-1:0] run_step, n_step;

`ifdef LSC_STRIDE_EN
    logic [A-1:0] stride_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stride_q <= '0;
        end else if (accept) begin
            stride_q <= cmd_stride;
        end
    end

    assign run_step = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^cmd_stride;
    assign run_step      = A'(1);
`endif

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign cnt_last = (cnt_q == L'(1));
    // Saturating decrement keeps the counter from underflowing on a stray advance.
    assign cnt_dec  = (cnt_q != '0) ? cnt_q - L'(1) : cnt_q;
    assign n_step   = (state_q == ST_RUN) ? run_step : A'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        k_inc       = 1'b0;
        n_inc       = 1'b0;
        in_ready    = 1'b0;
        kernelWrite = 1'b0;
        neuronWrite = 1'b0;
        mac_valid   = 1'b0;
        mac_first   = 1'b0;
        mac_last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d   = cmd_len;
                    first_d = 1'b1;
                    if (cmd_len == '0) begin
                        state_d = ST_FIN;
                    end else if (cmd_op == OPW'(OP_LOAD_K)) begin
                        state_d = ST_LOAD_K;
                    end else if (cmd_op == OPW'(OP_LOAD_N)) begin
                        state_d = ST_LOAD_N;
                    end else if (cmd_op == OPW'(OP_RUN)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_LOAD_K, ST_LOAD_N: begin
                in_ready    = 1'b1;
                kernelWrite = in_valid && (state_q == ST_LOAD_K);
                neuronWrite = in_valid && (state_q == ST_LOAD_N);
                if (in_valid) begin
                    k_inc = (state_q == ST_LOAD_K);
                    n_inc = (state_q == ST_LOAD_N);
                    cnt_d = cnt_dec;
                    if (cnt_last) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                mac_valid = 1'b1;
                mac_first = first_q;
                mac_last  = cnt_last;
                if (mac_ready) begin
                    k_inc   = 1'b1;
                    n_inc   = 1'b1;
                    first_d = 1'b0;
                    cnt_d   = cnt_dec;
                    if (cnt_last) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    lsc_addr_counter #(.A(A)) u_kptr (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .load_i (accept),
        .inc_i  (k_inc),
        .base_i (cmd_kbase),
        .step_i (A'(1)),
        .ptr_o  (kernelAddress)
    );

    lsc_addr_counter #(.A(A)) u_nptr (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .load_i (accept),
        .inc_i  (n_inc),
        .base_i (cmd_nbase),
        .step_i (n_step),
        .ptr_o  (neuronAddress)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
endmodule

// File: tb/tb_pe_local_store_sequencer.sv
// Directed bench for pe_local_store_sequencer; expected per-cycle outputs go through a scoreboard queue.
module tb_pe_local_store_sequencer;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_kbase, cmd_nbase, cmd_stride;
    logic [7:0] cmd_len;
    logic       in_valid, in_ready, mac_ready;
    logic [6:0] kernelAddress, neuronAddress;
    logic       kernelWrite, neuronWrite, mac_valid, mac_first, mac_last, busy, done;

    pe_local_store_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_kbase(cmd_kbase), .cmd_nbase(cmd_nbase), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
        .in_valid(in_valid), .in_ready(in_ready), .mac_ready(mac_ready),
        .kernelAddress(kernelAddress), .neuronAddress(neuronAddress),
        .kernelWrite(kernelWrite), .neuronWrite(neuronWrite),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Flag vector: {cmd_ready,in_ready,kW,nW,mac_valid,mac_first,mac_last,busy,done}
    localparam logic [8:0] F_IDLE = 9'b1_0000_0000;
    localparam logic [8:0] F_FIN  = 9'b0_0000_0011;
    localparam logic [8:0] F_LK   = 9'b0_1100_0010;
    localparam logic [8:0] F_LN   = 9'b0_1010_0010;
    localparam logic [8:0] F_LGAP = 9'b0_1000_0010;
    localparam logic [8:0] F_MV   = 9'b0_0001_0010;
    localparam logic [8:0] F_MVF  = 9'b0_0001_1010;
    localparam logic [8:0] F_MVL  = 9'b0_0001_0110;
    localparam logic [8:0] F_MVFL = 9'b0_0001_1110;

    typedef struct packed {
        logic [8:0] f;
        logic       kc;
        logic [6:0] ka;
        logic       nc;
        logic [6:0] na;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    logic [8:0] obs_f;
    assign obs_f = {cmd_ready, in_ready, kernelWrite, neuronWrite, mac_valid,
                    mac_first, mac_last, busy, done};

    // Called just after a falling edge with inputs already driven; checks this cycle's outputs.
    task automatic step(input string tag, input logic [8:0] f,
                        input logic kc, input logic [6:0] ka,
                        input logic nc, input logic [6:0] na);
        exp_t  e;
        string t;
        exp_q.push_back('{f: f, kc: kc, ka: ka, nc: nc, na: na});
        tag_q.push_back(tag);
        #2;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_total++;
        assert (obs_f === e.f) n_pass++;
        else $error("FAIL %s flags observed=%b expected=%b", t, obs_f, e.f);
        if (e.kc) begin
            n_total++;
            assert (kernelAddress === e.ka) n_pass++;
            else $error("FAIL %s kaddr observed=%h expected=%h", t, kernelAddress, e.ka);
        end
        if (e.nc) begin
            n_total++;
            assert (neuronAddress === e.na) n_pass++;
            else $error("FAIL %s naddr observed=%h expected=%h", t, neuronAddress, e.na);
        end
        @(negedge CLK);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [6:0] kb, input logic [6:0] nb,
                       input logic [7:0] len, input logic [6:0] stride);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_kbase  = kb;
        cmd_nbase  = nb;
        cmd_len    = len;
        cmd_stride = stride;
    endtask

    initial begin
        RST_N = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_kbase = '0; cmd_nbase = '0;
        cmd_len = '0; cmd_stride = '0; in_valid = 1'b0; mac_ready = 1'b0;
        @(negedge CLK);
        step("reset", F_IDLE, 1'b1, 7'h00, 1'b1, 7'h00);
        RST_N = 1'b1;
        step("idle", F_IDLE, 1'b1, 7'h00, 1'b1, 7'h00);

        // LOAD_K wrapping past the top of the store
        cmd(2'd0, 7'h7E, 7'h00, 8'd4, 7'h0);
        in_valid = 1'b1;
        step("lk_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        step("lk_b0", F_LK, 1'b1, 7'h7E, 1'b0, 7'h0);
        step("lk_b1", F_LK, 1'b1, 7'h7F, 1'b0, 7'h0);
        step("lk_b2", F_LK, 1'b1, 7'h00, 1'b0, 7'h0);
        step("lk_b3", F_LK, 1'b1, 7'h01, 1'b0, 7'h0);
        step("lk_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        in_valid = 1'b0;
        step("lk_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);

        // LOAD_N with a gap in in_valid
        cmd(2'd1, 7'h00, 7'h03, 8'd3, 7'h0);
        step("ln_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        step("ln_b0", F_LN, 1'b0, 7'h0, 1'b1, 7'h03);
        in_valid = 1'b0;
        step("ln_gap", F_LGAP, 1'b0, 7'h0, 1'b1, 7'h04);
        in_valid = 1'b1;
        step("ln_b1", F_LN, 1'b0, 7'h0, 1'b1, 7'h04);
        step("ln_b2", F_LN, 1'b0, 7'h0, 1'b1, 7'h05);
        in_valid = 1'b0;
        step("ln_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("ln_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);

        // RUN with MAC backpressure
        cmd(2'd2, 7'h00, 7'h10, 8'd3, 7'h1);
        step("run_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        mac_ready = 1'b1;
        step("run_p0", F_MVF, 1'b1, 7'h00, 1'b1, 7'h10);
        mac_ready = 1'b0;
        step("run_p1s", F_MV, 1'b1, 7'h01, 1'b1, 7'h11);
        mac_ready = 1'b1;
        step("run_p1", F_MV, 1'b1, 7'h01, 1'b1, 7'h11);
        step("run_p2", F_MVL, 1'b1, 7'h02, 1'b1, 7'h12);
        step("run_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("run_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);

        // RUN len=1 then RUN len=0 and reserved op
        cmd(2'd2, 7'h20, 7'h30, 8'd1, 7'h1);
        step("r1_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        step("r1_p0", F_MVFL, 1'b1, 7'h20, 1'b1, 7'h30);
        step("r1_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("r1_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd(2'd2, 7'h00, 7'h00, 8'd0, 7'h1);
        step("r0_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        step("r0_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("r0_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd(2'd3, 7'h00, 7'h00, 8'd5, 7'h1);
        step("op3_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        step("op3_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("op3_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);

        // RUN with stride (build-dependent neuron step)
        cmd(2'd2, 7'h00, 7'h7C, 8'd3, 7'h4);
        step("st_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
`ifdef LSC_STRIDE_EN
        step("st_p0", F_MVF, 1'b1, 7'h00, 1'b1, 7'h7C);
        step("st_p1", F_MV, 1'b1, 7'h01, 1'b1, 7'h00);
        step("st_p2", F_MVL, 1'b1, 7'h02, 1'b1, 7'h04);
`else
        step("st_p0", F_MVF, 1'b1, 7'h00, 1'b1, 7'h7C);
        step("st_p1", F_MV, 1'b1, 7'h01, 1'b1, 7'h7D);
        step("st_p2", F_MVL, 1'b1, 7'h02, 1'b1, 7'h7E);
`endif
        step("st_fin", F_FIN, 1'b0, 7'h0, 1'b0, 7'h0);
        step("st_idle", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);

        // Reset asserted mid-RUN aborts without done
        cmd(2'd2, 7'h05, 7'h15, 8'd5, 7'h1);
        step("rr_acc", F_IDLE, 1'b0, 7'h0, 1'b0, 7'h0);
        cmd_valid = 1'b0;
        step("rr_p0", F_MVF, 1'b1, 7'h05, 1'b1, 7'h15);
        step("rr_p1", F_MV, 1'b1, 7'h06, 1'b1, 7'h16);
        RST_N = 1'b0;
        step("rr_rst", F_IDLE, 1'b1, 7'h00, 1'b1, 7'h00);
        RST_N = 1'b1;
        step("rr_rel0", F_IDLE, 1'b1, 7'h00, 1'b1, 7'h00);
        step("rr_rel1", F_IDLE, 1'b1, 7'h00, 1'b1, 7'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
